// File: rtl/mips_pkg.sv
// Shared definitions for the mips host-side loader: sequencer states, error codes,
// and the halt opcode that is also decoded by the core.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_WDOG = 2'd2
    } err_t;

    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    function automatic logic is_halt(input logic [31:0] word, input logic [5:0] op);
        return word[31:26] == op;
    endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Loader bundle: program stream in, imem write port, core control, register read, dump stream out.
// master = the loader, slave = the host/core environment.
interface mips_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_clr;
    logic              cpu_run;
    logic              cpu_halted;
    logic [4:0]        reg_raddr;
    logic [31:0]       reg_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic [4:0]        m_idx;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    modport master (
        input  start, s_valid, s_data, s_last, cpu_halted, reg_rdata, m_ready,
        output s_ready, mem_we, mem_addr, mem_wdata, cpu_clr, cpu_run, reg_raddr,
               m_valid, m_data, m_idx, m_last, busy, done, err
    );

    modport slave (
        output start, s_valid, s_data, s_last, cpu_halted, reg_rdata, m_ready,
        input  s_ready, mem_we, mem_addr, mem_wdata, cpu_clr, cpu_run, reg_raddr,
               m_valid, m_data, m_idx, m_last, busy, done, err
    );

endinterface

// File: rtl/mips_wdog.sv
// Run watchdog: counts enabled cycles from a clear; expired flags the last allowed cycle.
module mips_wdog #(
    parameter int MAX_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(MAX_CYC - 1));

endmodule

// File: rtl/mips_prog_loader.sv
// Host-side sequencer: load program, clear and run the core until halt, dump registers.
// Optional LOADER_CHECKSUM_EN appends the 32-bit sum of loaded words as a final dump beat.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter int          NDUMP   = 32,
    parameter int          MAX_CYC = 4096,
    parameter logic [5:0]  HLT_OP  = HLT_OPCODE
) (
    input logic               clk1,
    input logic               rst_n,
    mips_prog_loader_if.master bus
);
    localparam logic [4:0] LAST_IDX = 5'(NDUMP - 1);

    state_t            state;
    err_t              err_r;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        idx;
    logic              wd_expired;
    logic              beat_in;
    logic              in_dump;
    logic              accept_start;
    logic              last_beat;
    logic [31:0]       beat_data;
    logic [4:0]        beat_idx;

    assign beat_in      = (state == S_LOAD) && bus.s_valid;
    assign in_dump      = (state == S_DUMP);
    assign accept_start = bus.start && ((state == S_IDLE) || (state == S_DONE));

    mips_wdog #(.MAX_CYC(MAX_CYC)) u_wdog (
        .clk     (clk1),
        .rst_n   (rst_n),
        .clr     (state == S_CLEAR),
        .en      ((state == S_RUN) && !bus.cpu_halted),
        .expired (wd_expired)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum;
    logic        csum_beat;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            csum      <= '0;
            csum_beat <= 1'b0;
        end else if (accept_start) begin
            csum      <= '0;
            csum_beat <= 1'b0;
        end else begin
            if (beat_in) csum <= csum + bus.s_data;
            if (in_dump && bus.m_ready && !csum_beat && (idx == LAST_IDX)) csum_beat <= 1'b1;
        end
    end

    assign last_beat = csum_beat;
    assign beat_data = csum_beat ? csum : bus.reg_rdata;
    assign beat_idx  = csum_beat ? 5'd0 : idx;
`else
    assign last_beat = (idx == LAST_IDX);
    assign beat_data = bus.reg_rdata;
    assign beat_idx  = idx;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            err_r <= ERR_OK;
            addr  <= '0;
            idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state <= S_LOAD;
                        err_r <= ERR_OK;
                        addr  <= '0;
                        idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.s_valid) begin
                        addr <= addr + ADDR_W'(1);
                        // A terminator in the last slot still counts as a clean load.
                        if (bus.s_last || is_halt(bus.s_data, HLT_OP)) begin
                            state <= S_CLEAR;
                        end else if (addr == '1) begin
                            err_r <= ERR_OVF;
                            state <= S_DONE;
                        end
                    end
                end
                S_CLEAR: state <= S_RUN;
                S_RUN: begin
                    if (bus.cpu_halted) begin
                        state <= S_DUMP;
                    end else if (wd_expired) begin
                        err_r <= ERR_WDOG;
                        state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (bus.m_ready) begin
                        if (last_beat)            state <= S_DONE;
                        else if (idx != LAST_IDX) idx   <= idx + 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output is a continuous decode of registered state (plus same-cycle
    // handshake inputs), so there is no combinational process that could infer a latch.
    assign bus.s_ready   = (state == S_LOAD);
    assign bus.mem_we    = beat_in;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = beat_in ? bus.s_data : '0;
    assign bus.cpu_clr   = (state == S_CLEAR);
    assign bus.cpu_run   = (state == S_RUN) && !bus.cpu_halted;
    assign bus.reg_raddr = in_dump ? idx : '0;
    assign bus.m_valid   = in_dump;
    assign bus.m_data    = in_dump ? beat_data : '0;
    assign bus.m_idx     = in_dump ? beat_idx : '0;
    assign bus.m_last    = in_dump && last_beat;
    assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_r;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a tiny instruction-level core model executes what the loader
// writes, and dump beats are compared with that model's register file.
module tb_mips_prog_loader;

    localparam int NDUMP = 6;
    localparam int MAXC  = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam int NBEATS = NDUMP + 1;
`else
    localparam int NBEATS = NDUMP;
`endif

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    logic        sel, start, s_valid, s_last, m_ready;
    logic [31:0] s_data;

    mips_prog_loader_if #(.ADDR_W(10)) ia ();
    mips_prog_loader_if #(.ADDR_W(3))  ib ();

    mips_prog_loader #(.ADDR_W(10), .NDUMP(NDUMP), .MAX_CYC(MAXC)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .bus(ia.master));
    mips_prog_loader #(.ADDR_W(3), .NDUMP(NDUMP), .MAX_CYC(MAXC)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .bus(ib.master));

    // Core model state
    logic [31:0] imem [1024];
    logic [31:0] regs [32];
    logic [9:0]  pc;
    logic        halted;
    bit          halt_en = 1'b1;
    bit          model_clr = 1'b0;
    int          n_writes = 0, n_clr = 0, n_run = 0;

    assign ia.start = start && !sel;
    assign ib.start = start && sel;
    assign ia.s_valid = s_valid && !sel;
    assign ib.s_valid = s_valid && sel;
    assign ia.s_data = s_data;
    assign ib.s_data = s_data;
    assign ia.s_last = s_last;
    assign ib.s_last = s_last;
    assign ia.m_ready = m_ready;
    assign ib.m_ready = m_ready;
    assign ia.cpu_halted = halted;
    assign ib.cpu_halted = halted;
    assign ia.reg_rdata = regs[ia.reg_raddr];
    assign ib.reg_rdata = regs[ib.reg_raddr];

    logic        s_ready, mem_we, cpu_clr, cpu_run, m_valid, m_last, busy, done;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, m_data;
    logic [4:0]  reg_raddr, m_idx;
    logic [1:0]  err;

    always_comb begin
        if (sel) begin
            s_ready = ib.s_ready; mem_we = ib.mem_we; mem_addr = {7'd0, ib.mem_addr};
            mem_wdata = ib.mem_wdata; cpu_clr = ib.cpu_clr; cpu_run = ib.cpu_run;
            reg_raddr = ib.reg_raddr; m_valid = ib.m_valid; m_data = ib.m_data;
            m_idx = ib.m_idx; m_last = ib.m_last; busy = ib.busy; done = ib.done; err = ib.err;
        end else begin
            s_ready = ia.s_ready; mem_we = ia.mem_we; mem_addr = ia.mem_addr;
            mem_wdata = ia.mem_wdata; cpu_clr = ia.cpu_clr; cpu_run = ia.cpu_run;
            reg_raddr = ia.reg_raddr; m_valid = ia.m_valid; m_data = ia.m_data;
            m_idx = ia.m_idx; m_last = ia.m_last; busy = ia.busy; done = ia.done; err = ia.err;
        end
    end

    // One instruction per run cycle: ADDI (0x0a), ADD (0x00), HLT (0x3f), others no-op.
    always @(posedge clk1) begin : core_model
        logic [31:0] ins;
        if (model_clr) begin
            for (int i = 0; i < 1024; i++) imem[i] <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            pc <= '0;
            halted <= 1'b0;
        end else begin
            if (mem_we) begin
                imem[mem_addr] <= mem_wdata;
                n_writes <= n_writes + 1;
            end
            if (cpu_clr) begin
                pc <= '0;
                halted <= 1'b0;
                n_clr <= n_clr + 1;
            end else if (cpu_run) begin
                ins = imem[pc];
                n_run <= n_run + 1;
                pc <= pc + 10'd1;
                case (ins[31:26])
                    6'h0a: if (ins[20:16] != 5'd0)
                        regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
                    6'h00: if (ins[15:11] != 5'd0)
                        regs[ins[15:11]] <= regs[ins[25:21]] + regs[ins[20:16]];
                    6'h3f: if (halt_en) halted <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    int tests = 0, fails = 0;
    int w0, c0, r0;
    logic [37:0] beats [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {34'd0, s_ready, mem_we, mem_addr, mem_wdata, cpu_clr, cpu_run, reg_raddr,
                m_valid, m_data, m_idx, m_last, busy, done, err};
    endfunction

    task automatic snap();
        w0 = n_writes; c0 = n_clr; r0 = n_run;
    endtask

    task automatic check_counts(input string tag, input int dw, input int dc, input int dr);
        check({tag, "_writes"}, n_writes - w0, dw);
        check({tag, "_clr"}, n_clr - c0, dc);
        check({tag, "_run"}, n_run - r0, dr);
    endtask

    task automatic clear_model();
        @(negedge clk1); model_clr = 1'b1;
        @(negedge clk1); model_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk1); start = 1'b1;
        @(negedge clk1); start = 1'b0;
    endtask

    task automatic load(input logic [31:0] w[$], input bit use_last, input int gap,
                        output logic [31:0] sum);
        int i = 0;
        int cyc = 0;
        sum = '0;
        while (i < w.size() && cyc < 400) begin
            @(negedge clk1);
            s_valid = ($urandom_range(99) >= gap);
            s_data  = w[i];
            s_last  = use_last && (i == w.size() - 1);
            #1;
            if (s_valid && s_ready) begin
                check("wr_we", mem_we, 1'b1);
                check("wr_addr", mem_addr, i);
                check("wr_data", mem_wdata, w[i]);
                sum += w[i];
                i++;
            end else if (s_ready) begin
                check("wr_idle", mem_we, 1'b0);
            end
            cyc++;
        end
        if (i < w.size()) check("load_timeout", i, w.size());
        @(negedge clk1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_dump(input int rmode, input bit poke, input logic [31:0] sum);
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [31:0] pdata = '0;
        logic [4:0] pidx = '0;
        beats.delete();
        while (!done && cyc < 400) begin
            @(negedge clk1);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2) == 1;
                default: m_ready = 1'($urandom_range(1));
            endcase
            start = poke && (cyc == 1);
            #1;
            if (prev_stall) begin
                check("hold_data", m_data, pdata);
                check("hold_idx", m_idx, pidx);
            end
            if (m_valid && m_ready) beats.push_back({m_idx, m_data, m_last});
            prev_stall = m_valid && !m_ready;
            pdata = m_data;
            pidx  = m_idx;
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b0;
        check("done", done, 1'b1);
        check("dump_beats", beats.size(), NBEATS);
        foreach (beats[k]) begin
            if (k < NBEATS) begin
                logic [4:0]  eidx;
                logic [31:0] edata;
                eidx  = (k < NDUMP) ? 5'(k) : 5'd0;
                edata = (k < NDUMP) ? regs[k] : sum;
                check($sformatf("dump_beat%0d", k), beats[k], {eidx, edata, k == NBEATS - 1});
            end
        end
    endtask

    initial begin : global_timeout
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog1[$];
        logic [31:0] prog[$];
        logic [31:0] sum;
        int exp_r[6] = '{0, 10, 20, 30, 30, 60};
        int n;
        bit hlt;

        prog1 = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h0ce77800, 32'h0ce77800,
                  32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        sel = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;

        // Reset state of both instances
        #12;
        check("reset_outs_a", all_outs(), '0);
        sel = 1'b1; #1;
        check("reset_outs_b", all_outs(), '0);
        sel = 1'b0;
        @(negedge clk1) rst_n = 1'b1;

        // 1: reference program, free-flowing dump
        clear_model(); snap(); pulse_start();
        load(prog1, 1'b0, 0, sum);
        run_dump(0, 1'b0, sum);
        for (int k = 0; k < NDUMP; k++)
            if (k < beats.size()) check($sformatf("s1_r%0d", k), beats[k][32:1], exp_r[k]);
        check_counts("s1", 9, 1, 9);
        check("s1_err", err, 2'd0);
        check("s1_busy", busy, 1'b0);

        // 2: same program, input gaps, m_ready toggling
        clear_model(); pulse_start();
        load(prog1, 1'b0, 30, sum);
        run_dump(1, 1'b0, sum);
        check("s2_err", err, 2'd0);

        // 3: ADDR_W=3 overflow without terminator
        sel = 1'b1;
        clear_model(); snap();
        prog.delete();
        for (int k = 0; k < 8; k++)
            prog.push_back({6'h0a, 5'($urandom_range(7)), 5'($urandom_range(1, 7)), 16'($urandom)});
        pulse_start();
        load(prog, 1'b0, 0, sum);
        check("s3_done", done, 1'b1);
        check("s3_err", err, 2'd1);
        check("s3_mvalid", m_valid, 1'b0);
        check_counts("s3", 8, 0, 0);
        sel = 1'b0;

        // 4: no halt, watchdog expiry; a start during RUN must be ignored
        halt_en = 1'b0;
        clear_model(); snap();
        prog = '{32'h28010005, 32'h28020007, 32'h00221800};
        pulse_start();
        load(prog, 1'b1, 0, sum);
        run_dump(0, 1'b1, sum);
        check_counts("s4", 3, 1, MAXC);
        check("s4_err", err, 2'd2);
        halt_en = 1'b1;

        // 5: asynchronous reset after three words, then a clean reload
        clear_model(); snap(); pulse_start();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1); s_valid = 1'b1; s_data = prog1[k];
        end
        @(negedge clk1); s_data = prog1[3];
        #2 rst_n = 1'b0;
        #1 check("s5_reset_outs", all_outs(), '0);
        check_counts("s5_pre", 3, 0, 0);
        s_valid = 1'b0;
        @(negedge clk1) rst_n = 1'b1;
        clear_model(); pulse_start();
        load(prog1, 1'b0, 0, sum);
        run_dump(2, 1'b0, sum);
        check("s5_err", err, 2'd0);

        // Randomised programs, terminated by HLT or by s_last alone
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(2, 7);
            hlt = 1'($urandom_range(1));
            prog.delete();
            for (int k = 0; k < n; k++)
                prog.push_back({6'h0a, 5'($urandom_range(7)), 5'($urandom_range(1, 7)),
                                16'($urandom)});
            if (hlt) prog.push_back({6'h3f, 26'($urandom)});
            clear_model(); snap(); pulse_start();
            load(prog, !hlt, 25, sum);
            run_dump(2, 1'b0, sum);
            check_counts($sformatf("rnd%0d", it), prog.size(), 1, hlt ? n + 1 : MAXC);
            check($sformatf("rnd%0d_err", it), err, hlt ? 2'd0 : 2'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
